// File: rtl/pc_fetch.sv
// pc_fetch: fetch-stage PC generator and instruction-fetch controller for the
// 5-stage MIPS pipeline. It generates pcF, runs one SRAM-like instruction bus
// transaction per instruction, and hands the result to the F/D register.
// Decode redirects (branch/jump) take effect after the delay-slot instruction
// currently in F has been handed off. Exceptions redirect immediately and
// abandon any in-flight bus transaction.
//
// Optional feature macro: FETCH_ADEL_EN. When it is defined, a misaligned
// pcF is never put on the bus. The fetch completes at once with instrF=0 and
// adelF=1.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   stallF                   decode not accepting; hold the instruction in F
//   exc_valid, exc_target    exception/eret redirect from M
//   branch_takenD, pc_branchD  taken branch in D and its target
//   jumpD, jump_conflictD, pc_jumpD  jump in D, source-hazard flag, target
//   inst_req, inst_addr      instruction bus request and address
//   inst_addr_ok, inst_data_ok, inst_rdata  bus handshake and read data
//   pcF, pc_plus4F           PC of the current fetch and its +4
//   instrF, instr_validF     fetched instruction and its valid flag
//   adelF                    (FETCH_ADEL_EN only) address-error on fetch
//
// state  | meaning
// -------+----------------------------------------------------------------
// REQ    | request for pcF on the bus, waiting for addr_ok
// WAIT   | address accepted, waiting for data_ok
// DONE   | instruction in instrF, waiting for decode to take it
// CANCEL | draining the data of a request abandoned by an exception
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallF,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        branch_takenD,
  input  logic [31:0] pc_branchD,
  input  logic        jumpD,
  input  logic        jump_conflictD,
  input  logic [31:0] pc_jumpD,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
  output logic [31:0] instrF,
`ifdef FETCH_ADEL_EN
  output logic        adelF,
`endif
  output logic        instr_validF
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

  state_t      state;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        handoff;
  logic        misaligned;
  logic        accepted;

  // A jr/jalr whose source is not yet written back is ignored. Decode keeps
  // presenting it until the conflict clears.
  assign redirect  = branch_takenD | (jumpD & ~jump_conflictD);
  assign target    = branch_takenD ? pc_branchD : pc_jumpD;
  assign pc_plus4F = pcF + 32'd4;
  assign next_pc   = redirect ? target : (pend_valid ? pend_target : pc_plus4F);
  // An exception wins over a handoff in the same cycle.
  assign handoff   = (state == S_DONE) && !stallF && !exc_valid;

`ifdef FETCH_ADEL_EN
  assign misaligned = (pcF[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign inst_req  = resetn && (state == S_REQ) && !misaligned;
  assign inst_addr = pcF;
  assign accepted  = inst_req && inst_addr_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_REQ;
      pcF          <= RESET_PC;
      instrF       <= 32'd0;
      instr_validF <= 1'b0;
      pend_valid   <= 1'b0;
      pend_target  <= 32'd0;
`ifdef FETCH_ADEL_EN
      adelF        <= 1'b0;
`endif
    end else if (exc_valid) begin
      pcF          <= exc_target;
      pend_valid   <= 1'b0;
      instr_validF <= 1'b0;
      instrF       <= 32'd0;
`ifdef FETCH_ADEL_EN
      adelF        <= 1'b0;
`endif
      // If the abandoned data returns in the exception cycle itself, nothing
      // is left outstanding, so go straight back to REQ instead of CANCEL.
      case (state)
        S_REQ:    state <= accepted ? S_CANCEL : S_REQ;
        S_WAIT:   state <= inst_data_ok ? S_REQ : S_CANCEL;
        S_CANCEL: state <= inst_data_ok ? S_REQ : S_CANCEL;
        S_DONE:   state <= S_REQ;
        default:  state <= S_REQ;
      endcase
    end else begin
      if (handoff) begin
        pend_valid <= 1'b0;
      end else if (redirect) begin
        pend_valid  <= 1'b1;
        pend_target <= target;
      end
      case (state)
        S_REQ: begin
          if (misaligned) begin
            instrF       <= 32'd0;
            instr_validF <= 1'b1;
`ifdef FETCH_ADEL_EN
            adelF        <= 1'b1;
`endif
            state        <= S_DONE;
          end else if (accepted) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            instrF       <= inst_rdata;
            instr_validF <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (!stallF) begin
            pcF          <= next_pc;
            instr_validF <= 1'b0;
            instrF       <= 32'd0;
`ifdef FETCH_ADEL_EN
            adelF        <= 1'b0;
`endif
            state        <= S_REQ;
          end
        end
        S_CANCEL: begin
          if (inst_data_ok) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
